// File: rtl/axi_sram_subordinate.sv
// AXI4+ATOP subordinate bridging one transaction at a time onto a 1-cycle-latency single-port SRAM.
// Optional WRAP burst support is enabled by defining AXI_SRAM_SUB_WRAP_EN.
module axi_sram_subordinate #(
  parameter int AxiIdWidth    = 4,
  parameter int AxiAddrWidth  = 64,
  parameter int AxiDataWidth  = 64,
  parameter int SramAddrWidth = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      aw_valid_i,
  output logic                      aw_ready_o,
  input  logic [AxiIdWidth-1:0]     aw_id_i,
  input  logic [AxiAddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]                aw_len_i,
  input  logic [2:0]                aw_size_i,
  input  logic [1:0]                aw_burst_i,
  input  logic [5:0]                aw_atop_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [AxiDataWidth-1:0]   w_data_i,
  input  logic [AxiDataWidth/8-1:0] w_strb_i,
  input  logic                      w_last_i,
  output logic                      b_valid_o,
  input  logic                      b_ready_i,
  output logic [AxiIdWidth-1:0]     b_id_o,
  output logic [1:0]                b_resp_o,
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  input  logic [AxiIdWidth-1:0]     ar_id_i,
  input  logic [AxiAddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]                ar_len_i,
  input  logic [2:0]                ar_size_i,
  input  logic [1:0]                ar_burst_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [AxiIdWidth-1:0]     r_id_o,
  output logic [AxiDataWidth-1:0]   r_data_o,
  output logic [1:0]                r_resp_o,
  output logic                      r_last_o,
  output logic                      sram_req_o,
  output logic                      sram_we_o,
  output logic [SramAddrWidth-1:0]  sram_addr_o,
  output logic [AxiDataWidth-1:0]   sram_wdata_o,
  output logic [AxiDataWidth/8-1:0] sram_be_o,
  input  logic [AxiDataWidth-1:0]   sram_rdata_i
);

  localparam int ByteBits = $clog2(AxiDataWidth / 8);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RREQ, RDATA} state_e;

  state_e                    state_q;
  logic                      prio_w_q;
  logic [AxiIdWidth-1:0]     id_q;
  logic [AxiAddrWidth-1:0]   addr_q;
  logic [7:0]                len_q;
  logic [7:0]                beat_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic                      err_q;
  logic                      b_valid_q;
  logic                      r_valid_q;
  logic                      r_last_q;
  logic [AxiDataWidth-1:0]   r_data_q;

  // Completion is counted by beats against len, so WLAST carries no information here.
  logic unused_w_last;
  assign unused_w_last = w_last_i;

  logic                    grant_w;
  logic                    grant_r;
  logic [AxiAddrWidth-1:0] cap_addr;
  logic [7:0]              cap_len;
  logic [2:0]              cap_size;
  logic [1:0]              cap_burst;
  logic                    wrap_legal;
  logic                    cap_err;

  assign grant_w = (state_q == IDLE) && aw_valid_i && (!ar_valid_i || prio_w_q);
  assign grant_r = (state_q == IDLE) && ar_valid_i && !grant_w;

  assign cap_addr  = grant_w ? aw_addr_i  : ar_addr_i;
  assign cap_len   = grant_w ? aw_len_i   : ar_len_i;
  assign cap_size  = grant_w ? aw_size_i  : ar_size_i;
  assign cap_burst = grant_w ? aw_burst_i : ar_burst_i;

`ifdef AXI_SRAM_SUB_WRAP_EN
  logic [AxiAddrWidth-1:0] cap_mask;
  assign cap_mask   = (AxiAddrWidth'(1) << cap_size) - AxiAddrWidth'(1);
  assign wrap_legal = ((cap_len == 8'd1) || (cap_len == 8'd3) || (cap_len == 8'd7) ||
                       (cap_len == 8'd15)) && ((cap_addr & cap_mask) == '0);
`else
  assign wrap_legal = 1'b0;
`endif

  assign cap_err = (cap_size > 3'(ByteBits)) || (cap_burst == 2'b11) ||
                   (grant_w && (aw_atop_i != '0)) || ((cap_burst == 2'b10) && !wrap_legal);

  logic [AxiAddrWidth-1:0] sz_bytes;
  logic [AxiAddrWidth-1:0] incr_addr;
  logic [AxiAddrWidth-1:0] next_addr;

  assign sz_bytes  = AxiAddrWidth'(1) << size_q;
  assign incr_addr = (addr_q & ~(sz_bytes - AxiAddrWidth'(1))) + sz_bytes;

`ifdef AXI_SRAM_SUB_WRAP_EN
  logic [AxiAddrWidth-1:0] wrap_bytes;
  logic [AxiAddrWidth-1:0] wrap_addr;
  assign wrap_bytes = AxiAddrWidth'({1'b0, len_q} + 9'd1) << size_q;
  assign wrap_addr  = (addr_q & ~(wrap_bytes - AxiAddrWidth'(1))) |
                      ((addr_q + sz_bytes) & (wrap_bytes - AxiAddrWidth'(1)));
`endif

  always_comb begin
    next_addr = incr_addr;
    case (burst_q)
      2'b00:   next_addr = addr_q;
`ifdef AXI_SRAM_SUB_WRAP_EN
      2'b10:   next_addr = wrap_addr;
`endif
      default: next_addr = incr_addr;
    endcase
  end

  // SRAM strobes fire in the handshake cycle so writes stream at one beat per cycle.
  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if ((state_q == WRITE) && w_valid_i && !err_q) begin
      sram_req_o   = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = SramAddrWidth'(addr_q >> ByteBits);
      sram_wdata_o = w_data_i;
      sram_be_o    = w_strb_i;
    end else if ((state_q == RREQ) && !err_q) begin
      sram_req_o  = 1'b1;
      sram_addr_o = SramAddrWidth'(addr_q >> ByteBits);
    end
  end

  assign aw_ready_o = grant_w;
  assign ar_ready_o = grant_r;
  assign w_ready_o  = (state_q == WRITE);
  assign b_valid_o  = b_valid_q;
  assign b_id_o     = id_q;
  assign b_resp_o   = err_q ? 2'b10 : 2'b00;
  assign r_valid_o  = r_valid_q;
  assign r_id_o     = id_q;
  assign r_data_o   = r_data_q;
  assign r_resp_o   = err_q ? 2'b10 : 2'b00;
  assign r_last_o   = r_last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      prio_w_q  <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      b_valid_q <= 1'b0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
      r_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_w || grant_r) begin
            id_q    <= grant_w ? aw_id_i : ar_id_i;
            addr_q  <= cap_addr;
            len_q   <= cap_len;
            size_q  <= cap_size;
            burst_q <= cap_burst;
            err_q   <= cap_err;
            beat_q  <= '0;
            state_q <= grant_w ? WRITE : RREQ;
            // Pointer only moves on contention; it then favours the loser.
            if (aw_valid_i && ar_valid_i) prio_w_q <= grant_r;
          end
        end
        WRITE: begin
          if (w_valid_i) begin
            addr_q <= next_addr;
            beat_q <= beat_q + 8'd1;
            if (beat_q == len_q) begin
              state_q   <= WRESP;
              b_valid_q <= 1'b1;
            end
          end
        end
        WRESP: begin
          if (b_ready_i) begin
            b_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        RREQ: state_q <= RDATA;
        RDATA: begin
          if (!r_valid_q) begin
            r_valid_q <= 1'b1;
            r_data_q  <= err_q ? '0 : sram_rdata_i;
            r_last_q  <= (beat_q == len_q);
          end else if (r_ready_i) begin
            r_valid_q <= 1'b0;
            if (r_last_q) begin
              state_q <= IDLE;
            end else begin
              addr_q  <= next_addr;
              beat_q  <= beat_q + 8'd1;
              state_q <= RREQ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_subordinate.sv
// Directed bench for axi_sram_subordinate with a behavioural 1-cycle SRAM.
module tb_axi_sram_subordinate;

  logic        clk_i, rst_ni;
  logic        aw_valid_i, aw_ready_o;
  logic [3:0]  aw_id_i;
  logic [63:0] aw_addr_i;
  logic [7:0]  aw_len_i;
  logic [2:0]  aw_size_i;
  logic [1:0]  aw_burst_i;
  logic [5:0]  aw_atop_i;
  logic        w_valid_i, w_ready_o;
  logic [63:0] w_data_i;
  logic [7:0]  w_strb_i;
  logic        w_last_i;
  logic        b_valid_o, b_ready_i;
  logic [3:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid_i, ar_ready_o;
  logic [3:0]  ar_id_i;
  logic [63:0] ar_addr_i;
  logic [7:0]  ar_len_i;
  logic [2:0]  ar_size_i;
  logic [1:0]  ar_burst_i;
  logic        r_valid_o, r_ready_i;
  logic [3:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic        sram_req_o, sram_we_o;
  logic [11:0] sram_addr_o;
  logic [63:0] sram_wdata_o;
  logic [7:0]  sram_be_o;
  logic [63:0] sram_rdata_i;

  int tests = 0;
  int fails = 0;
  int req_cnt = 0;
  int cnt0;
  logic both_rdy = 1'b0;
  logic [11:0] wr_q[$];
  bit [63:0] mem [0:4095];

  axi_sram_subordinate dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i), .aw_atop_i(aw_atop_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (sram_req_o) begin
      req_cnt++;
      if (sram_we_o) begin
        for (int b = 0; b < 8; b++)
          if (sram_be_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
        wr_q.push_back(sram_addr_o);
      end else begin
        sram_rdata_i <= mem[sram_addr_o];
      end
    end
  end

  always @(negedge clk_i) if (aw_ready_o && ar_ready_o) both_rdy = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, input logic [5:0] atop);
    aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_size_i = size;
    aw_burst_i = burst; aw_atop_i = atop; aw_valid_i = 1'b1;
  endtask

  task automatic set_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    ar_id_i = id; ar_addr_i = addr; ar_len_i = len; ar_size_i = size;
    ar_burst_i = burst; ar_valid_i = 1'b1;
  endtask

  task automatic wait_aw();
    int n = 0;
    @(negedge clk_i);
    while (!aw_ready_o && n < 100) begin @(negedge clk_i); n++; end
    check("aw_ready_wait", aw_ready_o, 1);
    @(posedge clk_i); #1 aw_valid_i = 1'b0;
  endtask

  task automatic wait_ar();
    int n = 0;
    @(negedge clk_i);
    while (!ar_ready_o && n < 100) begin @(negedge clk_i); n++; end
    check("ar_ready_wait", ar_ready_o, 1);
    @(posedge clk_i); #1 ar_valid_i = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] base, input int len);
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      w_valid_i = 1'b1; w_data_i = base * (i + 1); w_strb_i = 8'hFF; w_last_i = (i == len);
      @(negedge clk_i);
      while (!w_ready_o && n < 100) begin @(negedge clk_i); n++; end
      check("w_ready_wait", w_ready_o, 1);
      @(posedge clk_i); #1;
    end
    w_valid_i = 1'b0; w_last_i = 1'b0;
  endtask

  task automatic get_b(input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    b_ready_i = 1'b1;
    @(negedge clk_i);
    while (!b_valid_o && n < 100) begin @(negedge clk_i); n++; end
    check("b_valid_wait", b_valid_o, 1);
    check("b_id", b_id_o, id);
    check("b_resp", b_resp_o, resp);
    @(posedge clk_i); #1 b_ready_i = 1'b0;
  endtask

  // Every read in this bench starts at 0x100, whose words hold 0x11*(beat+1).
  task automatic recv_r(input logic [3:0] id, input int len, input logic [1:0] resp,
                        input int stall_beat);
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      int c0;
      logic [63:0] exp;
      exp = (resp == 2'b00) ? 64'h11 * (i + 1) : 64'h0;
      if (i == stall_beat) r_ready_i = 1'b0;
      @(negedge clk_i);
      while (!r_valid_o && n < 100) begin @(negedge clk_i); n++; end
      check("r_valid_wait", r_valid_o, 1);
      check("r_data", r_data_o, exp);
      check("r_last", r_last_o, (i == len));
      check("r_id", r_id_o, id);
      check("r_resp", r_resp_o, resp);
      if (i == stall_beat) begin
        c0 = req_cnt;
        repeat (5) begin
          @(negedge clk_i);
          check("stall_r_valid", r_valid_o, 1);
          check("stall_r_data", r_data_o, exp);
          check("stall_r_last", r_last_o, 0);
        end
        check("stall_no_req", req_cnt, c0);
        r_ready_i = 1'b1;
      end
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    aw_valid_i = 0; aw_id_i = 0; aw_addr_i = 0; aw_len_i = 0; aw_size_i = 0;
    aw_burst_i = 0; aw_atop_i = 0;
    w_valid_i = 0; w_data_i = 0; w_strb_i = 0; w_last_i = 0;
    b_ready_i = 0;
    ar_valid_i = 0; ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0; ar_size_i = 0; ar_burst_i = 0;
    r_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_aw_ready", aw_ready_o, 0);
    check("rst_ar_ready", ar_ready_o, 0);
    check("rst_w_ready", w_ready_o, 0);
    check("rst_b_valid", b_valid_o, 0);
    check("rst_r_valid", r_valid_o, 0);
    check("rst_sram_req", sram_req_o, 0);
    check("rst_sram_we", sram_we_o, 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Simultaneous AW/AR after reset: write wins; INCR write then read-back.
    set_aw(4'd3, 64'h100, 8'd3, 3'd3, 2'b01, 6'h0);
    set_ar(4'd5, 64'h100, 8'd3, 3'd3, 2'b01);
    @(negedge clk_i);
    check("arb1_aw_ready", aw_ready_o, 1);
    check("arb1_ar_ready", ar_ready_o, 0);
    @(posedge clk_i); #1 aw_valid_i = 1'b0;
    send_w(64'h11, 3);
    get_b(4'd3, 2'b00);
    check("incr_wr_count", wr_q.size(), 4);
    check("incr_wr_addr0", wr_q[0], 12'h020);
    check("incr_wr_addr1", wr_q[1], 12'h021);
    check("incr_wr_addr2", wr_q[2], 12'h022);
    check("incr_wr_addr3", wr_q[3], 12'h023);
    wait_ar();
    recv_r(4'd5, 3, 2'b00, -1);
    check("incr_req_total", req_cnt, 8);

    // Second contention: read wins this time.
    set_aw(4'd1, 64'h200, 8'd0, 3'd3, 2'b01, 6'h0);
    set_ar(4'd2, 64'h100, 8'd0, 3'd3, 2'b01);
    @(negedge clk_i);
    check("arb2_ar_ready", ar_ready_o, 1);
    check("arb2_aw_ready", aw_ready_o, 0);
    @(posedge clk_i); #1 ar_valid_i = 1'b0;
    recv_r(4'd2, 0, 2'b00, -1);
    wait_aw();
    send_w(64'hAA, 0);
    get_b(4'd1, 2'b00);

    // Atomic write: beats consumed, no SRAM access, SLVERR; memory keeps old data.
    cnt0 = req_cnt;
    set_aw(4'd4, 64'h100, 8'd1, 3'd3, 2'b01, 6'h20);
    wait_aw();
    send_w(64'h99, 1);
    get_b(4'd4, 2'b10);
    check("atop_no_req", req_cnt, cnt0);
    set_ar(4'd7, 64'h100, 8'd0, 3'd3, 2'b01);
    wait_ar();
    recv_r(4'd7, 0, 2'b00, -1);

    // Oversized read with reserved burst type.
    cnt0 = req_cnt;
    set_ar(4'd8, 64'h100, 8'd2, 3'd4, 2'b11);
    wait_ar();
    recv_r(4'd8, 2, 2'b10, -1);
    check("illegal_no_req", req_cnt, cnt0);

    // R backpressure on beat 2 of a 4-beat read.
    set_ar(4'd9, 64'h100, 8'd3, 3'd3, 2'b01);
    cnt0 = req_cnt;
    wait_ar();
    recv_r(4'd9, 3, 2'b00, 1);
    check("bp_req_total", req_cnt, cnt0 + 4);

    // WRAP burst from 0x118, 4 x 8 bytes.
    cnt0 = req_cnt;
    wr_q.delete();
    set_aw(4'd6, 64'h118, 8'd3, 3'd3, 2'b10, 6'h0);
    wait_aw();
    send_w(64'h5, 3);
`ifdef AXI_SRAM_SUB_WRAP_EN
    get_b(4'd6, 2'b00);
    check("wrap_wr_count", wr_q.size(), 4);
    check("wrap_wr_addr0", wr_q[0], 12'h023);
    check("wrap_wr_addr1", wr_q[1], 12'h020);
    check("wrap_wr_addr2", wr_q[2], 12'h021);
    check("wrap_wr_addr3", wr_q[3], 12'h022);
`else
    get_b(4'd6, 2'b10);
    check("wrap_no_req", req_cnt, cnt0);
`endif

    check("never_both_ready", both_rdy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
